caliptra_prim_sparse_fsm_mon: RTL and testbench
===============================================

# caliptra_prim_sparse_fsm_mon

Runtime monitor for sparse-encoded FSM state registers. Samples the state vector driven out of a sparse FSM flop, decodes it against the parameterised list of legal encodings, and flags undefined encodings and illegal transitions. Errors are sticky and counted, and each new error event is reported to the alert sender through a 4-phase req/ack handshake. It sits beside every hardened FSM and is the consumer end of the state register.

## Interface
- Width, 10: state vector width.
- NumStates, 4: number of legal encodings, 2..32.
- StateEnc, '0: packed array [NumStates][Width] of legal encodings. Entries are pairwise distinct; the bench asserts this at elaboration.
- ResetIdx, 0: index of the encoding held in the FSM flop at reset.
- TransLegal, '1: packed [NumStates][NumStates] bit matrix; bit [p][c]=1 means p->c is legal. The diagonal is treated as 1 regardless of its value.
- clk_i, input, 1: clock.
- rst_ni, input, 1: reset, synchronous, active-low.
- state_i, input, Width: state vector from the FSM flop.
- check_en_i, input, 1: enables error detection.
- clr_i, input, 1: clears sticky error status and the error counter.
- alert_ack_i, input, 1: acknowledge from the alert sender.
- state_idx_o, output, $clog2(NumStates): registered decoded index of the last defined state.
- state_idx_vld_o, output, 1: the last sampled state_i was defined.
- err_o, output, 1: sticky; set when any error is recorded.
- err_code_o, output, 2: sticky. Bit 0 is undefined encoding, bit 1 is illegal transition.
- err_cnt_o, output, 8: saturating count of error cycles.
- alert_req_o, output, 1: alert request.

## Operation
- Decode is combinational: match_idx is the index i where state_i == StateEnc[i]. undef is asserted when no entry matches.
- Internal registers: prev_idx (reset ResetIdx) and prev_vld (reset 1).
- trans_err = check_en_i & ~undef & prev_vld & ~TransLegal[prev_idx][match_idx] & (prev_idx != match_idx).
- undef_err = check_en_i & undef.
- err_now = undef_err | trans_err.
- Tracking runs every cycle, independent of check_en_i.
  - When the state is defined: prev_idx <= match_idx, prev_vld <= 1.
  - When the state is undefined: prev_idx holds, prev_vld <= 0. The next defined state therefore reloads tracking without a transition check.
- Sticky status:
  - On err_now: err_o <= 1 and err_code_o |= {trans_err, undef_err}.
  - err_cnt_o increments by 1 and saturates at 255.
- clr_i zeroes err_o, err_code_o and err_cnt_o.
  - If clr_i and err_now occur together, the error wins: err_o=1, err_code_o = the current error bits only, err_cnt_o=1.
  - clr_i does not affect the alert handshake.
- Alert handshake FSM, states IDLE, REQ, ACKWAIT:
  - IDLE: on err_now or pend, go to REQ and clear pend.
  - REQ: alert_req_o=1. On alert_ack_i=1, go to ACKWAIT.
  - ACKWAIT: alert_req_o=0. On alert_ack_i=0, go to IDLE.
  - err_now while in REQ or ACKWAIT sets the single-bit pend. Multiple errors collapse into one further alert.
  - An unencoded handshake state forces REQ and sets err_code_o[0].
- Reset values: all outputs 0 except state_idx_o=ResetIdx and state_idx_vld_o=1. FSM in IDLE, pend=0.
- Reset asserted mid-handshake drops alert_req_o at the next edge.

## Timing
- All outputs are registered.
- state_i sampled at edge k is reflected in state_idx_o, err_*, and alert_req_o after edge k, i.e. 1-cycle latency.
- alert_req_o rises at the same edge the error is recorded.
- Minimum handshake is 3 cycles: REQ, then ACKWAIT, then IDLE.
- A pending alert re-raises alert_req_o at the edge after returning to IDLE. The FSM transitions IDLE->REQ in one cycle.
- alert_ack_i asserted while in IDLE is ignored.
- An error cycle in which check_en_i=0 is neither counted nor alerted. Tracking still updates.

## Structure
- caliptra_prim_sparse_fsm_pkg holds:
  - alert_hs_state_e, a sparse 5-bit encoding with minimum Hamming distance 3.
  - ErrUndefIdx=0 and ErrTransIdx=1.
  - ErrCntW=8.
- Sub-module caliptra_prim_sparse_fsm_alert_hs implements the handshake FSM and pend. Its ports are clk_i, rst_ni, err_i, ack_i, req_o and hs_err_o.
- The top level implements decode, tracking and the sticky/counter logic.

## Test plan
Bench parameters: Width=6, NumStates=3, StateEnc={6'b101110, 6'b110100, 6'b001011} (idx 2,1,0), legal transitions 0->1, 1->2, 2->0, check_en_i=1.
- Defined-state sequence: drive idx 0,1,2,0,0 -> err_o=0, alert_req_o=0, state_idx_o follows with 1-cycle lag.
- Undefined encoding: drive 6'b000000 for 1 cycle -> err_code_o=2'b01, err_cnt_o=1, state_idx_vld_o=0.
  - Then ack 2 cycles later, release ack -> alert_req_o high 2 cycles, then IDLE.
- Illegal transition: drive 0 then 2 -> err_code_o=2'b10, alert_req_o=1.
  - Then 6'b000000 followed by idx 2 -> no transition error after the undefined cycle.
- Pending alert: a second error while in ACKWAIT -> alert_req_o re-asserts exactly 1 cycle after returning to IDLE. Only one extra alert even for 3 errors.
- Counter and clear: 300 undefined cycles -> err_cnt_o=255.
  - clr_i together with an error -> err_cnt_o=1, err_o=1.
  - clr_i alone -> all zero.
- Reset in REQ: rst_ni=0 for 1 cycle -> alert_req_o=0, state_idx_o=0, err_o=0 after that edge.

Source files
------------

// File: rtl/caliptra_prim_sparse_fsm_pkg.sv
// Shared definitions for the sparse FSM monitor.
//   alert_hs_state_e : sparse encoding of the alert handshake FSM. The three
//                      codes are pairwise at least 3 bits apart, so any single
//                      or double upset lands on an unused code.
//   ErrUndefIdx/ErrTransIdx : bit positions inside err_code_o.
//   ErrCntW          : width of the saturating error counter.
package caliptra_prim_sparse_fsm_pkg;

    localparam int ErrUndefIdx = 0;
    localparam int ErrTransIdx = 1;
    localparam int ErrCntW     = 8;

    // Pairwise Hamming distances: Idle/Req 4, Idle/AckWait 3, Req/AckWait 3.
    typedef enum logic [4:0] {
        HsIdle    = 5'b01101,
        HsReq     = 5'b10110,
        HsAckWait = 5'b11011
    } alert_hs_state_e;

endpackage

// File: rtl/caliptra_prim_sparse_fsm_alert_hs.sv
// Four-phase alert handshake toward the alert sender.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   err_i         : error event this cycle
//   ack_i         : acknowledge from the alert sender
//   req_o         : alert request (registered)
//   hs_err_o      : handshake state register holds an unused code
// Errors arriving while a handshake is in flight collapse into one pending
// bit, which fires exactly one further alert once the FSM is back in idle.
module caliptra_prim_sparse_fsm_alert_hs
    import caliptra_prim_sparse_fsm_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic err_i,
    input  logic ack_i,
    output logic req_o,
    output logic hs_err_o
);

    alert_hs_state_e state_q, state_d;
    logic            pend_q, pend_d;
    logic            req_q;

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        hs_err_o = 1'b0;
        unique case (state_q)
            HsIdle: begin
                if (err_i || pend_q) begin
                    state_d = HsReq;
                    pend_d  = 1'b0;
                end
            end
            HsReq: begin
                if (ack_i) state_d = HsAckWait;
                if (err_i) pend_d  = 1'b1;
            end
            HsAckWait: begin
                if (!ack_i) state_d = HsIdle;
                if (err_i)  pend_d  = 1'b1;
            end
            default: begin
                // Corrupted state register: fail safe by raising an alert.
                state_d  = HsReq;
                hs_err_o = 1'b1;
                if (err_i) pend_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= HsIdle;
            pend_q  <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            // Request flop mirrors the next state so it rises with the
            // edge that records the error.
            req_q   <= (state_d == HsReq);
        end
    end

    assign req_o = req_q;

endmodule

// File: rtl/caliptra_prim_sparse_fsm_mon.sv
// Runtime monitor for a sparse-encoded FSM state register.
//   clk_i, rst_ni    : clock, synchronous active-low reset
//   state_i          : state vector from the monitored FSM flop
//   check_en_i       : enables error detection (tracking always runs)
//   clr_i            : clears sticky status and counter
//   alert_ack_i      : acknowledge from the alert sender
//   state_idx_o      : index of the last defined state seen
//   state_idx_vld_o  : last sampled state was defined
//   err_o            : sticky error flag
//   err_code_o       : sticky {illegal transition, undefined encoding}
//   err_cnt_o        : saturating count of error cycles
//   alert_req_o      : alert request of the four-phase handshake
module caliptra_prim_sparse_fsm_mon
    import caliptra_prim_sparse_fsm_pkg::*;
#(
    parameter int                                   Width      = 10,
    parameter int                                   NumStates  = 4,
    parameter logic [NumStates-1:0][Width-1:0]      StateEnc   = '0,
    parameter int                                   ResetIdx   = 0,
    parameter logic [NumStates-1:0][NumStates-1:0]  TransLegal = '1,
    localparam int                                  IdxW       = $clog2(NumStates)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [Width-1:0]   state_i,
    input  logic               check_en_i,
    input  logic               clr_i,
    input  logic               alert_ack_i,
    output logic [IdxW-1:0]    state_idx_o,
    output logic               state_idx_vld_o,
    output logic               err_o,
    output logic [1:0]         err_code_o,
    output logic [ErrCntW-1:0] err_cnt_o,
    output logic               alert_req_o
);

    logic [IdxW-1:0] match_idx;
    logic            undef;
    logic [IdxW-1:0] prev_idx;
    logic            prev_vld;
    logic            undef_err, trans_err, err_now;
    logic            hs_err;
    logic [1:0]      err_bits;

    // Encodings are pairwise distinct, so at most one entry matches.
    always_comb begin
        match_idx = '0;
        undef     = 1'b1;
        for (int i = 0; i < NumStates; i++) begin
            if (state_i == StateEnc[i]) begin
                match_idx = IdxW'(i);
                undef     = 1'b0;
            end
        end
    end

    // Self-loops are always legal regardless of the matrix diagonal.
    // After an undefined cycle prev_vld is low, so the first defined state
    // only reloads tracking.
    assign undef_err = check_en_i & undef;
    assign trans_err = check_en_i & ~undef & prev_vld &
                       ~TransLegal[prev_idx][match_idx] & (prev_idx != match_idx);
    assign err_now   = undef_err | trans_err;

    always_comb begin
        err_bits              = 2'b00;
        err_bits[ErrUndefIdx] = undef_err | hs_err;
        err_bits[ErrTransIdx] = trans_err;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prev_idx <= IdxW'(ResetIdx);
            prev_vld <= 1'b1;
        end else if (!undef) begin
            prev_idx <= match_idx;
            prev_vld <= 1'b1;
        end else begin
            prev_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_o      <= 1'b0;
            err_code_o <= 2'b00;
            err_cnt_o  <= '0;
        end else if (clr_i) begin
            // A coincident error survives the clear as a fresh record.
            err_o      <= |err_bits;
            err_code_o <= err_bits;
            err_cnt_o  <= err_now ? ErrCntW'(1) : '0;
        end else begin
            if (|err_bits) err_o <= 1'b1;
            err_code_o <= err_code_o | err_bits;
            if (err_now && (err_cnt_o != {ErrCntW{1'b1}}))
                err_cnt_o <= err_cnt_o + ErrCntW'(1);
        end
    end

    caliptra_prim_sparse_fsm_alert_hs u_alert_hs (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .err_i    (err_now),
        .ack_i    (alert_ack_i),
        .req_o    (alert_req_o),
        .hs_err_o (hs_err)
    );

    assign state_idx_o     = prev_idx;
    assign state_idx_vld_o = prev_vld;

endmodule

// File: tb/tb_caliptra_prim_sparse_fsm_mon.sv
// Directed bench for caliptra_prim_sparse_fsm_mon with a 3-state, 6-bit
// sparse FSM whose legal ring is 0->1->2->0.
module tb_caliptra_prim_sparse_fsm_mon;

    localparam int W = 6;
    localparam int N = 3;
    localparam logic [W-1:0] E0 = 6'b001011;
    localparam logic [W-1:0] E1 = 6'b110100;
    localparam logic [W-1:0] E2 = 6'b101110;
    localparam logic [W-1:0] EU = 6'b000000;
    localparam logic [N-1:0][W-1:0] ENC = {E2, E1, E0};
    // Rows {p=2, p=1, p=0}; diagonal left at 0 on purpose.
    localparam logic [N-1:0][N-1:0] LEGAL = {3'b001, 3'b100, 3'b010};

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] state;
    logic         check_en;
    logic         clr;
    logic         ack;
    logic [1:0]   idx;
    logic         idx_vld;
    logic         err;
    logic [1:0]   code;
    logic [7:0]   cnt;
    logic         req;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    caliptra_prim_sparse_fsm_mon #(
        .Width      (W),
        .NumStates  (N),
        .StateEnc   (ENC),
        .ResetIdx   (0),
        .TransLegal (LEGAL)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .state_i         (state),
        .check_en_i      (check_en),
        .clr_i           (clr),
        .alert_ack_i     (ack),
        .state_idx_o     (idx),
        .state_idx_vld_o (idx_vld),
        .err_o           (err),
        .err_code_o      (code),
        .err_cnt_o       (cnt),
        .alert_req_o     (req)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_status();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; state = E0; check_en = 1'b1; clr = 1'b0; ack = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        checks++; if (idx !== 2'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", idx); end
        checks++; if (idx_vld !== 1'b1) begin errors++; $display("FAIL reset_vld got=%b exp=1", idx_vld); end
        checks++; if ({err, code, cnt, req} !== 12'd0) begin errors++;
            $display("FAIL reset_status got err=%b code=%b cnt=%0d req=%b exp all 0", err, code, cnt, req); end
    endtask

    task automatic test_defined_seq();
        logic [W-1:0] seq [5];
        int           exp_idx [5];
        seq = '{E0, E1, E2, E0, E0};
        exp_idx = '{0, 1, 2, 0, 0};
        for (int i = 0; i < 5; i++) begin
            state = seq[i];
            tick();
            checks++; if (idx !== 2'(exp_idx[i]) || idx_vld !== 1'b1) begin errors++;
                $display("FAIL seq_idx[%0d] got=%0d/%b exp=%0d/1", i, idx, idx_vld, exp_idx[i]); end
            checks++; if (err !== 1'b0 || req !== 1'b0) begin errors++;
                $display("FAIL seq_noerr[%0d] got err=%b req=%b exp 0/0", i, err, req); end
        end
    endtask

    task automatic test_undef();
        state = EU;
        tick();
        checks++; if (code !== 2'b01 || cnt !== 8'd1 || err !== 1'b1) begin errors++;
            $display("FAIL undef_status got code=%b cnt=%0d err=%b exp 01/1/1", code, cnt, err); end
        checks++; if (idx_vld !== 1'b0 || req !== 1'b1) begin errors++;
            $display("FAIL undef_vld_req got vld=%b req=%b exp 0/1", idx_vld, req); end
        state = E0;
        tick();
        checks++; if (req !== 1'b1 || idx_vld !== 1'b1 || cnt !== 8'd1) begin errors++;
            $display("FAIL undef_req2 got req=%b vld=%b cnt=%0d exp 1/1/1", req, idx_vld, cnt); end
        ack = 1'b1;
        tick();
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL undef_ackwait got req=%b exp 0", req); end
        ack = 1'b0;
        tick();
        tick();
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL undef_idle got req=%b exp 0", req); end
        clear_status();
    endtask

    task automatic test_illegal_trans();
        state = E2;   // tracking sits at idx 0; 0->2 is illegal
        tick();
        checks++; if (code !== 2'b10 || req !== 1'b1 || cnt !== 8'd1 || idx !== 2'd2) begin errors++;
            $display("FAIL trans_err got code=%b req=%b cnt=%0d idx=%0d exp 10/1/1/2", code, req, cnt, idx); end
        ack = 1'b1; tick(); ack = 1'b0; tick();
        clear_status();
        state = E0; tick();   // 2->0 legal
        state = EU; tick();
        state = E2; tick();   // tracking reload, no 0->2 check
        checks++; if (code !== 2'b01 || cnt !== 8'd1 || idx !== 2'd2 || idx_vld !== 1'b1) begin errors++;
            $display("FAIL trans_reload got code=%b cnt=%0d idx=%0d vld=%b exp 01/1/2/1", code, cnt, idx, idx_vld); end
        ack = 1'b1; tick(); ack = 1'b0; tick();
        clear_status();
    endtask

    task automatic test_pending();
        state = EU; ack = 1'b0;
        tick();
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL pend_first got req=%b exp 1", req); end
        state = E2; ack = 1'b1;
        tick();
        state = EU;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (req !== 1'b0) begin errors++; $display("FAIL pend_ackwait[%0d] got req=%b exp 0", i, req); end
        end
        state = E2; ack = 1'b0;
        tick();
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL pend_idle got req=%b exp 0", req); end
        tick();
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL pend_reraise got req=%b exp 1", req); end
        checks++; if (cnt !== 8'd4) begin errors++; $display("FAIL pend_cnt got=%0d exp=4", cnt); end
        ack = 1'b1; tick(); ack = 1'b0; tick();
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (req !== 1'b0) begin errors++; $display("FAIL pend_single[%0d] got req=%b exp 0", i, req); end
        end
        clear_status();
    endtask

    task automatic test_counter_clear();
        state = E1;   // tracking at idx 2; 2->1 is illegal
        tick();
        state = EU;
        for (int i = 0; i < 300; i++) tick();
        checks++; if (cnt !== 8'd255 || code !== 2'b11 || err !== 1'b1) begin errors++;
            $display("FAIL cnt_sat got cnt=%0d code=%b err=%b exp 255/11/1", cnt, code, err); end
        clr = 1'b1;
        tick();
        checks++; if (cnt !== 8'd1 || err !== 1'b1 || code !== 2'b01) begin errors++;
            $display("FAIL clr_with_err got cnt=%0d err=%b code=%b exp 1/1/01", cnt, err, code); end
        state = E2;
        tick();
        clr = 1'b0;
        checks++; if (cnt !== 8'd0 || err !== 1'b0 || code !== 2'b00) begin errors++;
            $display("FAIL clr_alone got cnt=%0d err=%b code=%b exp 0/0/00", cnt, err, code); end
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL clr_keeps_hs got req=%b exp 1", req); end
        ack = 1'b1; tick(); ack = 1'b0; tick();
        tick();   // pending alert fires again
        ack = 1'b1; tick(); ack = 1'b0; tick();
    endtask

    task automatic test_reset_in_req();
        state = EU;
        tick();
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL rst_req_pre got req=%b exp 1", req); end
        rst_n = 1'b0; state = E0;
        tick();
        rst_n = 1'b1;
        checks++; if (req !== 1'b0 || idx !== 2'd0 || err !== 1'b0 || idx_vld !== 1'b1) begin errors++;
            $display("FAIL rst_in_req got req=%b idx=%0d err=%b vld=%b exp 0/0/0/1", req, idx, err, idx_vld); end
        tick();
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL rst_no_pend got req=%b exp 0", req); end
    endtask

    task automatic test_check_disable();
        check_en = 1'b0;
        state = EU;
        tick();
        checks++; if (err !== 1'b0 || cnt !== 8'd0 || req !== 1'b0 || idx_vld !== 1'b0) begin errors++;
            $display("FAIL chk_dis_undef got err=%b cnt=%0d req=%b vld=%b exp 0/0/0/0", err, cnt, req, idx_vld); end
        state = E0; tick();
        state = E2; tick();   // illegal, but checking is off
        checks++; if (err !== 1'b0 || idx !== 2'd2 || req !== 1'b0) begin errors++;
            $display("FAIL chk_dis_trans got err=%b idx=%0d req=%b exp 0/2/0", err, idx, req); end
        check_en = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++)
            for (int j = i + 1; j < N; j++)
                if (ENC[i] == ENC[j]) begin
                    $display("FAIL enc_distinct entries %0d and %0d equal", i, j);
                    $fatal(1);
                end
        test_reset();
        test_defined_seq();
        test_undef();
        test_illegal_trans();
        test_pending();
        test_counter_clear();
        test_reset_in_req();
        test_check_disable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
